// File: rtl/switch_debounce_if.sv
`default_nettype none
// ============================================================================
//  switch_debounce_if
//  Switch-conditioner bus: raw pins in, debounced level and change pulses out.
//  Optional macro SWITCH_DEBOUNCE_EDGE_CAPTURE_EN adds edge_capture/edge_clear.
//  Revision: 1.0 - initial release
// ============================================================================
interface switch_debounce_if #(
    parameter int WIDTH = 17
);
    logic [WIDTH-1:0] sw_raw;
    logic [WIDTH-1:0] sw_stable;
    logic [WIDTH-1:0] sw_changed;
`ifdef SWITCH_DEBOUNCE_EDGE_CAPTURE_EN
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] edge_clear;

    // System side: drives the pins and the capture clears, reads conditioned state
    modport master (
        output sw_raw,
        output edge_clear,
        input  sw_stable,
        input  sw_changed,
        input  edge_capture
    );

    // Debouncer side
    modport slave (
        input  sw_raw,
        input  edge_clear,
        output sw_stable,
        output sw_changed,
        output edge_capture
    );
`else
    // System side: drives the pins, reads conditioned state
    modport master (
        output sw_raw,
        input  sw_stable,
        input  sw_changed
    );

    // Debouncer side
    modport slave (
        input  sw_raw,
        output sw_stable,
        output sw_changed
    );
`endif
endinterface
`default_nettype wire

// File: rtl/switch_debounce.sv
`default_nettype none
// ============================================================================
//  switch_debounce
//  Two-flop synchroniser plus per-bit stability counter for slide switches.
//  A bit's debounced level follows the synchronised input only after it has
//  disagreed for DEBOUNCE_CYCLES consecutive samples; a one-cycle pulse marks
//  each accepted toggle.
//  Optional feature macro: SWITCH_DEBOUNCE_EDGE_CAPTURE_EN (sticky edge flags
//  with per-bit clear, set dominates clear).
//  Revision: 1.0 - initial release
// ============================================================================
module switch_debounce #(
    parameter int               WIDTH           = 17,
    parameter int               DEBOUNCE_CYCLES = 50000,
    parameter int               CNT_W           = 16,
    parameter logic [WIDTH-1:0] INIT            = '0
) (
    input  wire logic         clk,
    input  wire logic         reset_n,
    switch_debounce_if.slave  bus
);

    // Terminal count; DEBOUNCE_CYCLES is limited to 2..2^CNT_W so this fits.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] s0;
    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] changed;
    logic [CNT_W-1:0] cnt [WIDTH];

    // Two-stage synchroniser for the asynchronous switch pins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s0 <= '0;
            s1 <= '0;
        end else begin
            s0 <= bus.sw_raw;
            s1 <= s0;
        end
    end

    // Per-bit debounce: any agreeing sample restarts the count, so only an
    // unbroken run of disagreement reaches the terminal count and is accepted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable  <= INIT;
            changed <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            changed <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                if (s1[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    stable[i]  <= s1[i];
                    changed[i] <= 1'b1;
                    cnt[i]     <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign bus.sw_stable  = stable;
    assign bus.sw_changed = changed;

`ifdef SWITCH_DEBOUNCE_EDGE_CAPTURE_EN
    logic [WIDTH-1:0] capture;

    // Sticky change flags; a new change in the same cycle as a clear wins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            capture <= '0;
        end else begin
            capture <= (capture & ~bus.edge_clear) | changed;
        end
    end

    assign bus.edge_capture = capture;
`endif

endmodule
`default_nettype wire

// File: tb/tb_switch_debounce.sv
`default_nettype none
// ============================================================================
//  tb_switch_debounce
//  Directed, table-driven bench for switch_debounce with DEBOUNCE_CYCLES=8.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_switch_debounce;

    localparam int W = 17;

    typedef struct {
        logic         rst_n;
        logic [W-1:0] raw;
        logic [W-1:0] exp_stable;
        logic [W-1:0] exp_changed;
        string        tag;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n;

    int n_vec = 0;
    int n_bad = 0;

    vec_t vecs[$];

    switch_debounce_if #(.WIDTH(W)) bus ();

    switch_debounce #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (8),
        .CNT_W           (16),
        .INIT            ('0)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %05h, expected %05h", name, act, exp);
        end
    endtask

    function automatic void push(input logic r, input logic [W-1:0] raw,
                                 input logic [W-1:0] st, input logic [W-1:0] ch,
                                 input string tag);
        vec_t v;
        v.rst_n = r; v.raw = raw; v.exp_stable = st; v.exp_changed = ch; v.tag = tag;
        vecs.push_back(v);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n    = 1'b0;
        bus.sw_raw = '0;
`ifdef SWITCH_DEBOUNCE_EDGE_CAPTURE_EN
        bus.edge_clear = '0;
`endif

        // Reset held with all switches high: outputs stay at INIT
        for (int j = 0; j < 3; j++) push(1'b0, 17'h1FFFF, 17'h00000, 17'h00000, "reset");
        // Clean step on bit 3: accepted at E0+9 only
        for (int j = 0; j < 11; j++)
            push(1'b1, 17'h00008, (j >= 9) ? 17'h00008 : 17'h00000,
                 (j == 9) ? 17'h00008 : 17'h00000, "clean_step");
        // 6-cycle glitch on bit 5 is rejected
        for (int j = 0; j < 16; j++)
            push(1'b1, (j < 6) ? 17'h00028 : 17'h00008, 17'h00008, 17'h00000, "glitch6");
        // 12-cycle pulse on bit 5: rises 9 after start, falls 9 after end
        for (int j = 0; j < 25; j++)
            push(1'b1, (j < 12) ? 17'h00028 : 17'h00008,
                 (j >= 9 && j < 21) ? 17'h00028 : 17'h00008,
                 (j == 9 || j == 21) ? 17'h00020 : 17'h00000, "pulse12");
        // Bounce on bit 0: 1,0,1,0 for 3 cycles each, then held 1
        for (int j = 0; j < 24; j++)
            push(1'b1, ((j / 3) % 2 == 0 || j >= 12) ? 17'h00009 : 17'h00008,
                 (j >= 21) ? 17'h00009 : 17'h00008,
                 (j == 21) ? 17'h00001 : 17'h00000, "bounce");

        #1;
        foreach (vecs[i]) begin
            reset_n    = vecs[i].rst_n;
            bus.sw_raw = vecs[i].raw;
            tick();
            check({vecs[i].tag, "_stable"},  bus.sw_stable,  vecs[i].exp_stable);
            check({vecs[i].tag, "_changed"}, bus.sw_changed, vecs[i].exp_changed);
`ifdef SWITCH_DEBOUNCE_EDGE_CAPTURE_EN
            if (!vecs[i].rst_n) check("reset_capture", bus.edge_capture, 17'h00000);
`endif
        end

        // Reset mid-count: bit 16 counted to 5 at E0+6, then reset discards it
        bus.sw_raw = 17'h10009;
        for (int k = 0; k < 7; k++) tick();
        check("midcnt_before", bus.sw_stable, 17'h00009);
        reset_n = 1'b0;
        #1;
        check("midcnt_async_stable", bus.sw_stable, 17'h00000);
        tick();
        tick();
        check("midcnt_in_reset", bus.sw_stable, 17'h00000);
        reset_n = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            tick();
            check("midcnt_stable",  bus.sw_stable,  (k >= 10) ? 17'h10009 : 17'h00000);
            check("midcnt_changed", bus.sw_changed, (k == 10) ? 17'h10009 : 17'h00000);
        end

`ifdef SWITCH_DEBOUNCE_EDGE_CAPTURE_EN
        check("cap_after_midcnt", bus.edge_capture, 17'h10009);
        bus.edge_clear = '1;
        tick();
        check("cap_clear_all", bus.edge_capture, 17'h00000);
        bus.edge_clear = '0;
        // Raise bit 1; flag would set at E0+10
        bus.sw_raw = 17'h1000B;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check("cap_wait", bus.edge_capture, 17'h00000);
        end
        check("cap_changed", bus.sw_changed, 17'h00002);
        bus.edge_clear = 17'h00002;
        tick();
        check("cap_set_wins", bus.edge_capture, 17'h00002);
        tick();
        check("cap_clear", bus.edge_capture, 17'h00000);
        bus.edge_clear = '0;
        tick();
        check("cap_stays_clear", bus.edge_capture, 17'h00000);
        check("cap_stable", bus.sw_stable, 17'h1000B);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/switch_debounce.md
# switch_debounce

Input conditioner between the DE2 slide switches and the 17-bit switch PIO (`SWITCH_I`) in the Nios II system. The block synchronises each asynchronous switch line into `clk` and debounces it with a per-bit counter. It drives a glitch-free `sw_stable` bus into the PIO `in_port`, plus a one-cycle change pulse per bit. An optional sticky edge-capture register is available for software polling.

## Interface
- `WIDTH`, 17, number of switch lines.
- `DEBOUNCE_CYCLES`, 50000, consecutive stable cycles required before a change is accepted (1 ms at 50 MHz); legal range 2..2^CNT_W.
- `CNT_W`, 16, per-bit counter width.
- `INIT`, 0 (WIDTH bits), reset value of `sw_stable`.

- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `sw_raw`  in  WIDTH  asynchronous switch pins.
- `sw_stable`  out  WIDTH  debounced switch state; connects to the PIO `in_port`.
- `sw_changed`  out  WIDTH  one-cycle pulse on the cycle `sw_stable[i]` toggles.
- `edge_capture`  out  WIDTH  sticky change flags; present only with the macro.
- `edge_clear`  in  WIDTH  per-bit clear for `edge_capture`; present only with the macro.

## Operation
- **Synchroniser.** Each bit passes through two flops, `s0` then `s1`. Reset value of both is 0.
- **Counter rule.** Each bit `i` owns a counter `cnt[i]` of CNT_W bits. Every clock edge, the following applies:
  - If `s1[i] == sw_stable[i]`: `cnt[i] <= 0`.
  - Else if `cnt[i] == DEBOUNCE_CYCLES-1`: `sw_stable[i] <= s1[i]`, `cnt[i] <= 0`, `sw_changed[i] <= 1`.
  - Else: `cnt[i] <= cnt[i]+1`.
  - `sw_changed[i]` defaults to 0 on every other edge.
- **Glitches.** A mismatch that lasts fewer than DEBOUNCE_CYCLES sampled cycles leaves `sw_stable` unchanged. A single matching sample clears the counter, so the full count restarts.
- **Bit independence.** Bits are independent. Several bits may toggle on the same edge, and `sw_changed` then has multiple bits set.
- **Counter range.** No counter wraps: each counter is cleared on reaching DEBOUNCE_CYCLES-1.
- **Reset values.**
  - `sw_stable = INIT`, `sw_changed = 0`, all `cnt = 0`, `s0 = s1 = 0`.
  - With the macro: `edge_capture = 0`.
- **Reset mid-count.** Asserting `reset_n` mid-count discards progress. After release, debouncing starts from the reset state. If a raw bit differs from `INIT`, `sw_stable` reaches the raw value DEBOUNCE_CYCLES+1 cycles after the first post-reset edge.

## Timing
- `sw_raw` is captured by `s0` at edge E0, and `s1` updates at E0+1.
- The first mismatch is counted at E0+2.
- `sw_stable` and `sw_changed` update at edge E0+DEBOUNCE_CYCLES+1, provided the raw level is held throughout.
- `sw_changed` is high for exactly one cycle.
- All outputs are registered, so there is no combinational path from input to output.
- With the macro, `edge_capture[i]` sets on the edge after `sw_changed[i]` is high. One cycle of added latency is acceptable.
- `edge_clear[i]` clears the flag on the next edge. If set and clear occur in the same cycle, set wins.

## Configuration
- Macro: `SWITCH_DEBOUNCE_EDGE_CAPTURE_EN`.
- **Defined:**
  - `edge_capture` and `edge_clear` ports exist.
  - `edge_capture[i] <= (edge_capture[i] & ~edge_clear[i]) | sw_changed[i]`.
- **Undefined:**
  - Neither port exists and no capture flops are built.
  - Only `sw_stable` and `sw_changed` are produced.

## Test plan
Benches use `DEBOUNCE_CYCLES=8`, `INIT=0`, `WIDTH=17`.
- **Reset:** hold `reset_n=0` with `sw_raw=17'h1FFFF` -> `sw_stable=0`, `sw_changed=0`, `edge_capture=0`.
- **Clean step:** step `sw_raw[3]` 0->1 at E0 and hold -> `sw_stable=17'h00008` and `sw_changed=17'h00008` at E0+9 for one cycle; no change at E0+8.
- **Glitch rejection:** pulse `sw_raw[5]` high for 6 cycles, then low -> `sw_stable` stays 0 and no `sw_changed`. Follow with a 12-cycle pulse -> bit 5 rises 9 cycles after the pulse start and falls 9 cycles after the pulse end.
- **Bounce:** toggle `sw_raw[0]` 1,0,1,0,1 at 3-cycle spacing, then hold 1 -> exactly one `sw_changed[0]` pulse, 9 cycles after the final 0->1.
- **Reset mid-count:** apply `reset_n=0` at count 5 of a bit-16 change -> after release with the raw level still 1, the bit rises 9 cycles after the first post-reset edge.
- **Edge capture (macro on):** raise `sw_raw[1]`, pulse `edge_clear[1]` on the same cycle the flag would set -> `edge_capture[1]=1`. Next cycle, pulse `edge_clear[1]` alone -> `edge_capture[1]=0`.
